// File: rtl/reg_file_arbiter.sv
// Arbitrates a single-ported 16x8 register file between operand fetch (dual read)
// and writeback (single write), with a one-entry write buffer and address-window checks.
module reg_file_arbiter #(
    parameter int unsigned PRIORITY_MODE = 0,
    parameter int unsigned MAX_REG       = 16
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       wr_valid,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       wr_drop,

    input  logic       rd_valid,
    input  logic [4:0] rd_rs,
    input  logic [4:0] rd_rt,
    output logic       rd_ready,

    output logic       rsp_valid,
    output logic [7:0] rsp_rs_data,
    output logic [7:0] rsp_rt_data,

    output logic       rf_rw,
    output logic [4:0] rf_rs,
    output logic [4:0] rf_rt,
    output logic [4:0] rf_rd,
    output logic [7:0] rf_rd_data,
    input  logic [7:0] rf_rs_data,
    input  logic [7:0] rf_rt_data
);

    typedef enum logic {
        GrantRead,
        GrantWrite
    } grant_e;

    function automatic logic addr_legal(input logic [4:0] a);
        return (a != 5'd0) && (32'(a) <= MAX_REG);
    endfunction

    logic       buf_valid_q;
    logic [4:0] buf_addr_q;
    logic [7:0] buf_data_q;
    grant_e     last_grant_q;
    logic       wr_drop_q;

    logic       rd_pend_q;
    logic       rs_ill_q;
    logic       rt_ill_q;
    logic [7:0] rsp_rs_q;
    logic [7:0] rsp_rt_q;

    logic [4:0] rf_rs_q;
    logic [4:0] rf_rt_q;
    logic [4:0] rf_rd_q;
    logic [7:0] rf_rd_data_q;

    logic wr_accept;
    logic wr_legal;
    logic rs_legal;
    logic rt_legal;
    logic hazard;
    logic contended;
    logic grant_wr;
    logic grant_rd;

    assign wr_accept = wr_valid && !buf_valid_q;
    assign wr_legal  = addr_legal(wr_addr);
    assign rs_legal  = addr_legal(rd_rs);
    assign rt_legal  = addr_legal(rd_rt);

    // A read touching the buffered register must wait for the write to land.
    assign hazard = buf_valid_q &&
                    ((rs_legal && (rd_rs == buf_addr_q)) ||
                     (rt_legal && (rd_rt == buf_addr_q)));

    assign contended = !rst && buf_valid_q && rd_valid;

    // Grants are gated by rst so a buffered write cannot commit during reset.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!rst) begin
            if (buf_valid_q && rd_valid) begin
                if (hazard || (PRIORITY_MODE == 1) || (last_grant_q == GrantRead)) begin
                    grant_wr = 1'b1;
                end else begin
                    grant_rd = 1'b1;
                end
            end else if (buf_valid_q) begin
                grant_wr = 1'b1;
            end else if (rd_valid) begin
                grant_rd = 1'b1;
            end
        end
    end

    assign wr_ready = !buf_valid_q;
    assign wr_drop  = wr_drop_q;
    assign rd_ready = grant_rd;
    assign rf_rw    = grant_wr;

    // File addresses hold their last driven value when not in use.
    assign rf_rs      = grant_rd ? rd_rs      : rf_rs_q;
    assign rf_rt      = grant_rd ? rd_rt      : rf_rt_q;
    assign rf_rd      = grant_wr ? buf_addr_q : rf_rd_q;
    assign rf_rd_data = grant_wr ? buf_data_q : rf_rd_data_q;

    assign rsp_valid   = rd_pend_q;
    assign rsp_rs_data = rd_pend_q ? (rs_ill_q ? 8'h00 : rf_rs_data) : rsp_rs_q;
    assign rsp_rt_data = rd_pend_q ? (rt_ill_q ? 8'h00 : rf_rt_data) : rsp_rt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q  <= 1'b0;
            buf_addr_q   <= 5'd0;
            buf_data_q   <= 8'h00;
            last_grant_q <= GrantRead;
            wr_drop_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            rs_ill_q     <= 1'b0;
            rt_ill_q     <= 1'b0;
            rsp_rs_q     <= 8'h00;
            rsp_rt_q     <= 8'h00;
            rf_rs_q      <= 5'd0;
            rf_rt_q      <= 5'd0;
            rf_rd_q      <= 5'd0;
            rf_rd_data_q <= 8'h00;
        end else begin
            if (grant_wr) begin
                buf_valid_q <= 1'b0;
            end else if (wr_accept && wr_legal) begin
                buf_valid_q <= 1'b1;
            end
            if (wr_accept && wr_legal) begin
                buf_addr_q <= wr_addr;
                buf_data_q <= wr_data;
            end
            wr_drop_q <= wr_accept && !wr_legal;

            if (contended) begin
                last_grant_q <= grant_wr ? GrantWrite : GrantRead;
            end

            rd_pend_q <= grant_rd;
            if (grant_rd) begin
                rs_ill_q <= !rs_legal;
                rt_ill_q <= !rt_legal;
            end
            rsp_rs_q <= rsp_rs_data;
            rsp_rt_q <= rsp_rt_data;

            rf_rs_q      <= rf_rs;
            rf_rt_q      <= rf_rt;
            rf_rd_q      <= rf_rd;
            rf_rd_data_q <= rf_rd_data;
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed bench: one arbiter in alternate mode (dut0), one in write-priority mode (dut1),
// each backed by a small register-file model whose unwritten entries read as {3'b110, addr}.
module tb_reg_file_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic mdl_clr;

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic       wv0, rv0, wr_ready0, wr_drop0, rd_ready0, rsp_v0, rf_rw0;
    logic [4:0] wa0, rs0, rt0, rf_rs0, rf_rt0, rf_rd0;
    logic [7:0] wd0, rsp_rs0, rsp_rt0, rf_wd0, rf_rsd0, rf_rtd0;

    logic       wv1, rv1, wr_ready1, wr_drop1, rd_ready1, rsp_v1, rf_rw1;
    logic [4:0] wa1, rs1, rt1, rf_rs1, rf_rt1, rf_rd1;
    logic [7:0] wd1, rsp_rs1, rsp_rt1, rf_wd1, rf_rsd1, rf_rtd1;

    reg_file_arbiter #(.PRIORITY_MODE(0), .MAX_REG(16)) dut0 (
        .clk(clk), .rst(rst),
        .wr_valid(wv0), .wr_addr(wa0), .wr_data(wd0), .wr_ready(wr_ready0), .wr_drop(wr_drop0),
        .rd_valid(rv0), .rd_rs(rs0), .rd_rt(rt0), .rd_ready(rd_ready0),
        .rsp_valid(rsp_v0), .rsp_rs_data(rsp_rs0), .rsp_rt_data(rsp_rt0),
        .rf_rw(rf_rw0), .rf_rs(rf_rs0), .rf_rt(rf_rt0), .rf_rd(rf_rd0), .rf_rd_data(rf_wd0),
        .rf_rs_data(rf_rsd0), .rf_rt_data(rf_rtd0)
    );

    reg_file_arbiter #(.PRIORITY_MODE(1), .MAX_REG(16)) dut1 (
        .clk(clk), .rst(rst),
        .wr_valid(wv1), .wr_addr(wa1), .wr_data(wd1), .wr_ready(wr_ready1), .wr_drop(wr_drop1),
        .rd_valid(rv1), .rd_rs(rs1), .rd_rt(rt1), .rd_ready(rd_ready1),
        .rsp_valid(rsp_v1), .rsp_rs_data(rsp_rs1), .rsp_rt_data(rsp_rt1),
        .rf_rw(rf_rw1), .rf_rs(rf_rs1), .rf_rt(rf_rt1), .rf_rd(rf_rd1), .rf_rd_data(rf_wd1),
        .rf_rs_data(rf_rsd1), .rf_rt_data(rf_rtd1)
    );

    logic [7:0]  mem0 [32];
    logic [7:0]  mem1 [32];
    logic [31:0] wmask0;
    logic [31:0] wmask1;

    always @(posedge clk) begin
        if (mdl_clr) begin
            wmask0 <= '0;
        end else if (rf_rw0) begin
            mem0[rf_rd0]   <= rf_wd0;
            wmask0[rf_rd0] <= 1'b1;
        end else begin
            rf_rsd0 <= wmask0[rf_rs0] ? mem0[rf_rs0] : {3'b110, rf_rs0};
            rf_rtd0 <= wmask0[rf_rt0] ? mem0[rf_rt0] : {3'b110, rf_rt0};
        end
    end

    always @(posedge clk) begin
        if (mdl_clr) begin
            wmask1 <= '0;
        end else if (rf_rw1) begin
            mem1[rf_rd1]   <= rf_wd1;
            wmask1[rf_rd1] <= 1'b1;
        end else begin
            rf_rsd1 <= wmask1[rf_rs1] ? mem1[rf_rs1] : {3'b110, rf_rs1};
            rf_rtd1 <= wmask1[rf_rt1] ? mem1[rf_rt1] : {3'b110, rf_rt1};
        end
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_rw0, exp_rsp0, exp_rw1, exp_rsp1;

    initial begin
        rst = 1'b1; mdl_clr = 1'b1;
        wv0 = 1'b0; wa0 = 5'd0; wd0 = 8'h00; rv0 = 1'b0; rs0 = 5'd0; rt0 = 5'd0;
        wv1 = 1'b0; wa1 = 5'd0; wd1 = 8'h00; rv1 = 1'b0; rs1 = 5'd0; rt1 = 5'd0;
        step();
        step();
        rst = 1'b0; mdl_clr = 1'b0;
        #1;
        check1("rst_rsp_valid", rsp_v0, 1'b0);
        check1("rst_wr_drop", wr_drop0, 1'b0);
        check1("rst_rf_rw", rf_rw0, 1'b0);
        check8("rst_rf_rs", 8'(rf_rs0), 8'h00);
        check8("rst_rf_rd", 8'(rf_rd0), 8'h00);
        check8("rst_rf_rd_data", rf_wd0, 8'h00);
        check8("rst_rsp_rs", rsp_rs0, 8'h00);
        check1("rst_wr_ready", wr_ready0, 1'b1);

        // Write r5 = A3, then read it back alongside illegal r0.
        wv0 = 1'b1; wa0 = 5'd5; wd0 = 8'hA3;
        #1;
        check1("wr_ready_idle", wr_ready0, 1'b1);
        step();
        wv0 = 1'b0;
        #1;
        check1("wr_ready_busy", wr_ready0, 1'b0);
        check1("wr_commit_rw", rf_rw0, 1'b1);
        check8("wr_commit_rd", 8'(rf_rd0), 8'h05);
        check8("wr_commit_data", rf_wd0, 8'hA3);
        step();
        rv0 = 1'b1; rs0 = 5'd5; rt0 = 5'd0;
        #1;
        check1("wr_ready_back", wr_ready0, 1'b1);
        check1("rd_rf_rw", rf_rw0, 1'b0);
        check1("rd_ready_1", rd_ready0, 1'b1);
        check8("rd_rf_rs", 8'(rf_rs0), 8'h05);
        step();
        rv0 = 1'b0;
        #1;
        check1("rsp_valid_1", rsp_v0, 1'b1);
        check8("rsp_rs_r5", rsp_rs0, 8'hA3);
        check8("rsp_rt_r0", rsp_rt0, 8'h00);
        step();
        check1("rsp_valid_drop", rsp_v0, 1'b0);
        check8("rsp_rs_hold", rsp_rs0, 8'hA3);

        // Illegal write to r17 is dropped; illegal read of r17 zero-fills.
        wv0 = 1'b1; wa0 = 5'd17; wd0 = 8'hFF;
        #1;
        step();
        wv0 = 1'b0;
        #1;
        check1("wr_drop_pulse", wr_drop0, 1'b1);
        check1("wr_drop_no_rw", rf_rw0, 1'b0);
        step();
        check1("wr_drop_clear", wr_drop0, 1'b0);
        check1("wr_drop_no_rw2", rf_rw0, 1'b0);
        check1("wr_drop_ready", wr_ready0, 1'b1);
        rv0 = 1'b1; rs0 = 5'd17; rt0 = 5'd5;
        #1;
        check1("rd_ready_ill", rd_ready0, 1'b1);
        step();
        rv0 = 1'b0;
        check1("rsp_valid_ill", rsp_v0, 1'b1);
        check8("rsp_rs_r17", rsp_rs0, 8'h00);
        check8("rsp_rt_r5", rsp_rt0, 8'hA3);

        // Contended cycle grants WRITE (last=READ after reset), leaving last=WRITE.
        wv0 = 1'b1; wa0 = 5'd9; wd0 = 8'h99;
        #1;
        step();
        wv0 = 1'b0; rv0 = 1'b1; rs0 = 5'd2; rt0 = 5'd4;
        #1;
        check1("contend_w_rw", rf_rw0, 1'b1);
        check1("contend_w_rdy", rd_ready0, 1'b0);
        check8("contend_w_rd", 8'(rf_rd0), 8'h09);
        step();
        wv0 = 1'b1; wa0 = 5'd3; wd0 = 8'h11;
        #1;
        check1("uncontend_r", rd_ready0, 1'b1);
        check1("uncontend_r_rw", rf_rw0, 1'b0);
        step();
        // Buffer holds r3 and last=WRITE, but the hazard must still force WRITE.
        wv0 = 1'b0; rs0 = 5'd3; rt0 = 5'd4;
        #1;
        check1("rsp_valid_r2r4", rsp_v0, 1'b1);
        check8("rsp_rs_r2", rsp_rs0, 8'hC2);
        check8("rsp_rt_r4", rsp_rt0, 8'hC4);
        check1("hazard_rw", rf_rw0, 1'b1);
        check1("hazard_rdy", rd_ready0, 1'b0);
        check8("hazard_rd", 8'(rf_rd0), 8'h03);
        check8("hazard_data", rf_wd0, 8'h11);
        step();
        check1("hazard_then_r", rd_ready0, 1'b1);
        check1("hazard_then_rw", rf_rw0, 1'b0);
        check8("hazard_rf_rs", 8'(rf_rs0), 8'h03);
        check1("hazard_no_rsp", rsp_v0, 1'b0);
        step();
        check1("hazard_rsp_v", rsp_v0, 1'b1);
        check8("hazard_rsp_rs", rsp_rs0, 8'h11);
        check8("hazard_rsp_rt", rsp_rt0, 8'hC4);

        // Continuous disjoint traffic on both instances.
        wv0 = 1'b1; wa0 = 5'd10; wd0 = 8'h5A; rs0 = 5'd1; rt0 = 5'd2;
        wv1 = 1'b1; wa1 = 5'd10; wd1 = 8'h5A; rv1 = 1'b1; rs1 = 5'd1; rt1 = 5'd2;
        exp_rw0  = 8'b0010_0100;
        exp_rsp0 = 8'b1011_0111;
        exp_rw1  = 8'b1010_1010;
        exp_rsp1 = 8'b1010_1010;
        for (int i = 0; i < 8; i++) begin
            #1;
            check1($sformatf("alt_rw_%0d", i), rf_rw0, exp_rw0[i]);
            check1($sformatf("alt_rdy_%0d", i), rd_ready0, !exp_rw0[i]);
            check1($sformatf("alt_rsp_%0d", i), rsp_v0, exp_rsp0[i]);
            check1($sformatf("pri_rw_%0d", i), rf_rw1, exp_rw1[i]);
            check1($sformatf("pri_rdy_%0d", i), rd_ready1, !exp_rw1[i]);
            check1($sformatf("pri_rsp_%0d", i), rsp_v1, exp_rsp1[i]);
            step();
        end
        wv0 = 1'b0;
        wv1 = 1'b0; rv1 = 1'b0;
        #1;
        check1("alt_tail_w", rf_rw0, 1'b1);
        check8("pri_rsp_rs", rsp_rs1, 8'hC1);
        check8("pri_rsp_rt", rsp_rt1, 8'hC2);

        // Read granted with r12 buffered, then reset: r12 must never be committed.
        step();
        wv0 = 1'b1; wa0 = 5'd12; wd0 = 8'h77;
        #1;
        check1("pre_rst_r", rd_ready0, 1'b1);
        step();
        wv0 = 1'b0;
        #1;
        check1("rd_with_buf", rd_ready0, 1'b1);
        check1("rd_with_buf_rw", rf_rw0, 1'b0);
        check1("rd_with_buf_full", wr_ready0, 1'b0);
        step();
        rv0 = 1'b0; rst = 1'b1;
        #1;
        check1("rst_no_commit", rf_rw0, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check1("post_rst_rsp_v", rsp_v0, 1'b0);
        check1("post_rst_wr_rdy", wr_ready0, 1'b1);
        check1("post_rst_rw", rf_rw0, 1'b0);
        check8("post_rst_rf_rs", 8'(rf_rs0), 8'h00);
        check8("post_rst_rf_rt", 8'(rf_rt0), 8'h00);
        check8("post_rst_rf_rd", 8'(rf_rd0), 8'h00);
        check8("post_rst_rf_wd", rf_wd0, 8'h00);
        check8("post_rst_rsp_rs", rsp_rs0, 8'h00);
        check8("post_rst_rsp_rt", rsp_rt0, 8'h00);
        check1("post_rst_drop", wr_drop0, 1'b0);
        rv0 = 1'b1; rs0 = 5'd12; rt0 = 5'd0;
        #1;
        check1("post_rst_rd", rd_ready0, 1'b1);
        step();
        rv0 = 1'b0;
        #1;
        check1("post_rst_rsp", rsp_v0, 1'b1);
        check8("r12_uncommitted", rsp_rs0, 8'hCC);
        check8("r0_zero", rsp_rt0, 8'h00);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
